// File: rtl/filter2d_pack.sv
// filter2d_pack: packs the 8-bit filter2d pixel stream into addressed 32-bit words behind a small FIFO.
// Optional checksum of each completed frame is compiled in with FILTER2D_PACK_CKSUM_EN.
module filter2d_pack #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_strb,
    input  logic [7:0]        i_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [31:0]       o_wdata,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_frame_done,
    output logic              o_overflow,
    output logic [15:0]       o_cksum
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int WORDS = TOTAL / 4;
    localparam int PIX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORDS - 1);
    localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    logic [1:0]        gi;
    logic [23:0]       lo_bytes;
    logic [ADDR_W-1:0] wa;
    logic [PIX_W-1:0]  pix_cnt;
    logic              pix_last;

    logic [31:0]           mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]     mem_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [PTR_W:0]        count;

    logic full, pop, push_try, push;

    assign pix_last = (pix_cnt == PIX_LAST);
    assign full     = (count == DEPTH_C);
    assign o_valid  = (count != '0);
    assign pop      = o_valid & o_ready;
    assign push_try = i_strb & (gi == 2'd3);
    // A full FIFO still accepts the word when the head leaves in the same cycle.
    assign push     = push_try & (~full | pop);

    assign o_wdata = o_valid ? mem_data[rd_ptr] : 32'h0;
    assign o_addr  = o_valid ? mem_addr[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gi           <= 2'd0;
            lo_bytes     <= 24'h0;
            wa           <= '0;
            pix_cnt      <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            o_overflow   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= pop & mem_last[rd_ptr];
            if (i_strb) begin
                gi      <= gi + 2'd1;
                pix_cnt <= pix_last ? '0 : pix_cnt + PIX_W'(1);
                case (gi)
                    2'd0:    lo_bytes[7:0]   <= i_data;
                    2'd1:    lo_bytes[15:8]  <= i_data;
                    2'd2:    lo_bytes[23:16] <= i_data;
                    default: ;
                endcase
            end
            // Address advances even for dropped words so later words land correctly.
            if (push_try)
                wa <= (wa == ADDR_LAST) ? '0 : wa + ADDR_W'(1);
            if (push_try && !push)
                o_overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= {i_data, lo_bytes};
            mem_addr[wr_ptr] <= wa;
            mem_last[wr_ptr] <= pix_last;
        end
    end

`ifdef FILTER2D_PACK_CKSUM_EN
    logic [15:0] acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= 16'h0;
            o_cksum <= 16'h0;
        end else if (i_strb) begin
            if (pix_last) begin
                o_cksum <= acc + {8'h00, i_data};
                acc     <= 16'h0;
            end else begin
                acc <= acc + {8'h00, i_data};
            end
        end
    end
`else
    assign o_cksum = 16'h0000;
`endif

endmodule

// File: doc/filter2d_pack.md
# filter2d_pack

Downstream collector for the `filter2d` stage. It takes the strobed 8-bit output pixel stream, packs four consecutive pixels into a 32-bit word, and tags each word with a frame-relative word address. Words are buffered in a small FIFO and presented on a valid/ready write port toward the frame-memory writer. The block also flags frame completion and FIFO overflow.

## Interface
Parameters:
- `IMG_W`, 256, pixels per line
- `IMG_H`, 256, lines per frame
- `FIFO_DEPTH`, 4, word entries; must be a power of two, ≥2
- `ADDR_W`, 14, word-address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H/4

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `i_strb` in 1: pixel valid for one cycle (connects to `filter2d` `o_strb`)
- `i_data` in 8: pixel (connects to `filter2d` `o_data`)
- `o_valid` in/out: out 1: FIFO head word valid
- `o_ready` in 1: writer accepts head word
- `o_wdata` out 32: packed word
- `o_addr` out ADDR_W: word address of head word
- `o_frame_done` out 1: one-cycle pulse, last word of frame accepted
- `o_overflow` out 1: sticky, a word was dropped
- `o_cksum` out 16: checksum of last completed frame

## Operation
- Packing is little-endian: the first pixel of a group goes to [7:0] and the fourth to [31:24].
- The group index `gi` (0..3) advances on each `i_strb`.
- On the strobe that carries the 4th pixel, the word is assembled from the three stored bytes plus `i_data`. It is pushed in the same edge together with the current word address `wa`.
- `wa` increments on every push attempt, including dropped ones. This keeps later words at their correct address.
- `wa` wraps to 0 after IMG_W*IMG_H/4 − 1.
- The pixel counter tracks frame position and wraps at IMG_W*IMG_H. IMG_W*IMG_H must be divisible by 4, so a frame always ends on a word boundary.
- Push is permitted when the FIFO is not full, or when it is full and a pop (`o_valid && o_ready`) occurs in the same cycle.
- A push that is not permitted drops the word and sets `o_overflow`. `o_overflow` clears only on `reset`.
- Pop occurs on `o_valid && o_ready`. `o_wdata` and `o_addr` hold stable while `o_valid` is high and `o_ready` is low.
- Each FIFO entry carries a last-of-frame tag, set when the entry's address is the final word address.
- `o_frame_done` pulses on the cycle after the tagged entry pops.
- If the last word of a frame was dropped, no `o_frame_done` is emitted for that frame.
- Reset (at any time): FIFO emptied, `gi`, `wa` and the pixel counter cleared, partial group discarded.
  - All outputs reset to 0.
  - `o_wdata` and `o_addr` read 0 when empty.

## Timing
- Latency: 4th pixel sampled at edge N gives `o_valid` = 1 after edge N (visible in cycle N+1), provided the FIFO was empty.
- Throughput: one pixel per cycle is sustained, i.e. one word per 4 cycles, while `o_ready` = 1.
- `o_ready` has no combinational path to `i_*`, and `o_valid` does not depend combinationally on `o_ready`.
- `o_frame_done` is registered: high exactly 1 cycle, one edge after the final handshake.
- Boundary cases:
  - Empty FIFO: `o_valid` = 0.
  - Full FIFO with push and pop together: both succeed, occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.

## Configuration
- Macro: `FILTER2D_PACK_CKSUM_EN`.
- Defined:
  - A 16-bit accumulator adds every sampled pixel, modulo 2^16, zero-extended.
  - On the edge sampling the frame's last pixel, `o_cksum` is loaded with the accumulator value plus that pixel, and the accumulator is cleared.
  - The accumulator and `o_cksum` are reset to 0.
- Undefined: no accumulator logic is compiled; `o_cksum` is tied to 16'h0000.

## Test plan
- Reset then four strobes 8'h11, 8'h22, 8'h33, 8'h44 with `o_ready` = 1 → one cycle later `o_valid` = 1, `o_wdata` = 32'h44332211, `o_addr` = 0; popped next edge.
- `o_ready` = 0 and 5 words (20 strobes) pushed, depth 4 → first 4 words buffered at addresses 0..3; 5th dropped; `o_overflow` = 1. Then `o_ready` = 1 → exactly 4 words drain; the next word pushed carries `o_addr` = 5.
- FIFO full, then 4th pixel arrives on the same cycle `o_ready` = 1 → no drop, `o_overflow` stays 0, occupancy still 4.
- Full 256×256 frame, one pixel every 17 cycles, all pixels = 8'h01 → 16384 words at addresses 0..16383, `o_frame_done` pulses once after address 16383 pops. With the macro defined, `o_cksum` = 16'h0000 (65536 mod 2^16); second frame restarts at address 0.
- Assert `reset` after 2 strobes mid-frame, release, send 8'hAA, 8'hBB, 8'hCC, 8'hDD → word 32'hDDCCBBAA at `o_addr` = 0, `o_overflow` = 0.
- Frame of pixels 8'hFF with the macro defined → `o_cksum` = (65536×255) mod 65536 = 16'h0000. Frame where only pixel 0 = 8'h05 and all others = 0 → `o_cksum` = 16'h0005.
